// File: rtl/local_inj_queue_pkg.sv
// Shared constants for the local injection queue: flit layout and queue defaults.
package local_inj_queue_pkg;

    localparam int unsigned FLIT_WIDTH        = 32;
    localparam int unsigned VALID_POS         = FLIT_WIDTH - 1;
    localparam int unsigned TIME_POS          = 0;
    localparam int unsigned INJ_DEPTH         = 4;
    localparam int unsigned INJ_STARVE_THRESH = 16;

endpackage

// File: rtl/inj_fifo_mem.sv
// Register array for the injection queue: one synchronous write port, one asynchronous read port.
module inj_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents need no reset: occupancy gates every read that matters.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/local_inj_queue.sv
// Per-node injection FIFO feeding the local stage inject port, with head-of-line starvation tracking.
// Optional macro LOCAL_INJ_THROTTLE_EN: while starve is set, enq_ready is held low.
module local_inj_queue
    import local_inj_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = FLIT_WIDTH,
    parameter int unsigned DEPTH         = INJ_DEPTH,
    parameter int unsigned CNT_WIDTH     = 3,
    parameter int unsigned STARVE_THRESH = INJ_STARVE_THRESH,
    parameter int unsigned STARVE_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] enq_flit,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    output logic [DATA_WIDTH-1:0] inj_flit,
    input  logic                  inj_grant,
    input  logic                  inj_merge,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  starve
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrWidth-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]    occ_q, occ_d;
    logic [STARVE_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
    logic [DATA_WIDTH-1:0]   wr_flit;
    logic [DATA_WIDTH-1:0]   head_flit;
    logic                    full, empty, push, pop;

    assign full  = (occ_q == CNT_WIDTH'(DEPTH));
    assign empty = (occ_q == '0);

`ifdef LOCAL_INJ_THROTTLE_EN
    assign enq_ready = !full && !starve;
`else
    assign enq_ready = !full;
`endif

    assign push = enq_valid && enq_ready;
    assign pop  = (inj_grant || inj_merge) && !empty;

    always_comb begin
        wr_flit            = enq_flit;
        wr_flit[VALID_POS] = 1'b1;
    end

    inj_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PtrWidth)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_flit),
        .raddr (rd_ptr_q),
        .rdata (head_flit)
    );

    // Empty queue presents an all-zero flit so the local stage sees no request.
    assign inj_flit  = empty ? '0 : head_flit;
    assign occupancy = occ_q;
    assign starve    = (starve_cnt_q == STARVE_WIDTH'(STARVE_THRESH));

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        occ_d = occ_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        if (empty || pop) begin
            starve_cnt_d = '0;
        end else if (!starve) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            starve_cnt_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: doc/local_inj_queue.md
Name: local_inj_queue

Overview:
- Per-node injection FIFO that sits directly upstream of the router's local eject/inject stage.
- Accepts flits from the node interface, holds them, and presents the head flit on the injection port (`in_4` of the local stage).
- Pops the head when the local stage grants injection on any channel, or when the flit is merged into a passing flit.
- Tracks head-of-line starvation for source throttling.

Parameters:
- DATA_WIDTH, `DATA_WIDTH from global.vh, flit width.
- DEPTH, 4, queue entries (power of two, ≥2).
- CNT_WIDTH, 3, occupancy width; must hold the value DEPTH.
- STARVE_THRESH, 16, consecutive blocked cycles before starvation is flagged.
- STARVE_WIDTH, 5, width of the starvation counter; must hold STARVE_THRESH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enq_flit  in  DATA_WIDTH  flit from node interface
- enq_valid  in  1  enq_flit valid
- enq_ready  out  1  queue can accept this cycle
- inj_flit  out  DATA_WIDTH  head flit to local stage injection port
- inj_grant  in  1  OR of local stage inj_en_0..3 this cycle
- inj_merge  in  1  local stage merge[4]: head merged into a passing flit
- occupancy  out  CNT_WIDTH  current entry count
- starve  out  1  head blocked ≥ STARVE_THRESH cycles

Behaviour:
- Clock, reset: one clock `clk`; `reset` synchronous, active-high.
- Reset values:
  - pointers = 0, occupancy = 0, starvation counter = 0.
  - enq_ready = 1, inj_flit = 0, starve = 0.
- Storage: circular buffer of DEPTH entries; rd_ptr/wr_ptr wrap modulo DEPTH; full when occupancy == DEPTH.
- Enqueue:
  - push = enq_valid && enq_ready.
  - enq_ready = (occupancy != DEPTH); registered-state only, no combinational path from inj_grant.
  - A pushed flit is written with its VALID_POS bit forced to 1.
- Head output:
  - inj_flit is combinational from rd_ptr when occupancy != 0.
  - inj_flit = 0 when empty, so VALID_POS = 0 and the local stage sees no request.
- Dequeue:
  - pop = (inj_grant || inj_merge) && occupancy != 0.
  - inj_grant and inj_merge together pop exactly one entry.
  - Grant or merge while empty is ignored.
- Latency:
  - A push into an empty queue appears on inj_flit the next cycle; no same-cycle bypass.
  - A pop advances the head the next cycle.
- Simultaneous push and pop:
  - occupancy unchanged; both pointers advance.
  - When full, push is blocked by enq_ready = 0 even if a pop occurs that cycle.
- Occupancy update: occupancy_next = occupancy + push − pop, computed in CNT_WIDTH bits; it can never wrap.
- Starvation counter:
  - Increments while the queue is non-empty and pop = 0; saturates at STARVE_THRESH.
  - Cleared on pop or when the queue is empty.
  - starve = (counter == STARVE_THRESH), registered.
- Reset mid-operation: all contents are discarded; pointers, occupancy, counter and starve are cleared on the next edge with reset high.

Optional Feature:
- Macro: LOCAL_INJ_THROTTLE_EN.
- Defined:
  - While starve = 1, enq_ready is forced to 0, blocking new node traffic until the head is injected.
  - starve clears the cycle after the pop.
- Undefined:
  - starve is output only (monitoring); enq_ready depends only on fullness.

Decomposition:
- Shared package / global.vh additions:
  - INJ_DEPTH and STARVE_THRESH defaults.
- Reused from global.vh: DATA_WIDTH, VALID_POS, TIME_POS.
- One natural sub-module: `inj_fifo_mem`, the DEPTH×DATA_WIDTH register array with write port and asynchronous read. Pointers, counters and throttle logic stay in local_inj_queue.

Test Plan:
- Reset then idle → inj_flit = 0, occupancy = 0, enq_ready = 1, starve = 0.
- Push flits A, B, C on consecutive cycles with no grant → occupancy 1, 2, 3; inj_flit = A from the cycle after A's push, valid bit = 1.
- Fill to 4 entries, then assert enq_valid → enq_ready = 0 and no write. Next, inj_grant with enq_valid → occupancy 3, enq_ready back to 1.
- Occupancy 2, inj_grant and inj_merge both high for one cycle → occupancy 1; head advances by exactly one entry.
- Occupancy 1, simultaneous push D and inj_grant → occupancy stays 1; inj_flit = D the next cycle.
- Head blocked 16 cycles → starve = 1 on cycle 16.
  - With LOCAL_INJ_THROTTLE_EN: enq_ready = 0 while starve is set.
  - On inj_grant: starve = 0 the next cycle.
